pb_bus_master: RTL and testbench
================================

PB_BUS_MASTER -- requirements
Module: pb_bus_master

Interface
REQ-001 SHALL provide parameter SETUP_CYCLES, default 1, legal 1..15: cycles port_id/out_port are held stable before the strobe cycle.
REQ-002 SHALL provide ports, clock and reset first:
 clk  input  1  single clock, all state on rising edge
 reset  input  1  asynchronous, active-low reset
 cmd_valid  input  1  command offered
 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high
 cmd_write  input  1  1 = port write, 0 = port read
 cmd_addr  input  8  target port_id
 cmd_wdata  input  8  write data
 rsp_valid  output  1  read data available
 rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high
 rsp_data  output  8  captured read data
 port_id  output  8  Picoblaze-style port address
 out_port  output  8  write data to peripherals
 in_port  input  8  OR-ed peripheral data_out
 write_strobe  output  1  one-cycle write pulse
 read_strobe  output  1  one-cycle read pulse
 interrupt  input  1  peripheral interrupt (e.g. pb_timer)
 irq_pending  output  1  latched interrupt
 irq_clear  input  1  clears irq_pending

Function
REQ-003 SHALL implement the FSM IDLE -> SETUP -> STROBE -> (write: IDLE | read: RESP -> IDLE).
REQ-004 SHALL drive cmd_ready high only in IDLE; on acceptance, cmd_addr, cmd_wdata and cmd_write are registered into port_id, out_port and a direction flag.
REQ-005 SHALL hold SETUP for exactly SETUP_CYCLES cycles, with strobes low and port_id/out_port stable.
REQ-006 STROBE SHALL last exactly one cycle: write_strobe is high for a write, read_strobe for a read, never both.
REQ-007 For reads, in_port SHALL be sampled into rsp_data on the clock edge ending STROBE; rsp_valid rises on the next cycle.
REQ-008 RESP SHALL hold rsp_valid and rsp_data stable until rsp_ready; the handshake cycle returns the FSM to IDLE.
REQ-009 Write latency SHALL be 1+SETUP_CYCLES cycles from acceptance to the strobe cycle; the next cmd_ready follows one cycle later.
REQ-010 Read latency SHALL be SETUP_CYCLES+2 cycles from acceptance to rsp_valid.
REQ-011 port_id and out_port SHALL retain their last values in IDLE; they change only on acceptance.
REQ-012 cmd_valid is ignored outside IDLE; no queuing.
REQ-013 The SETUP counter is 4 bits and SHALL never wrap; SETUP_CYCLES outside 1..15 is a parameter error.

Reset
REQ-014 Asserting reset SHALL immediately force: FSM to IDLE, cmd_ready 1, rsp_valid 0, rsp_data 8'h00, port_id 8'h00, out_port 8'h00, both strobes 0, irq_pending 0, synchronizer flops 0.
REQ-015 Reset asserted during SETUP or STROBE SHALL abort the transaction with no residual strobe and no response.

Configuration
REQ-016 Macro PB_BUS_MASTER_IRQ_EN defined: interrupt passes through a 2-flop synchronizer; a rising edge sets irq_pending; irq_clear clears it; a simultaneous edge and clear leaves irq_pending 1.
REQ-017 Macro undefined: irq_pending is tied 0, and interrupt and irq_clear are unused.

Structure
REQ-018 Shared package pb_bus_pkg SHALL hold the FSM state encoding (IDLE, SETUP, STROBE, RESP) and the constant PB_DATA_W = 8.
REQ-019 Sub-module pb_irq_sync SHALL hold the synchronizer and edge latch and is instantiated only under PB_BUS_MASTER_IRQ_EN.

Verification
REQ-020 Write cmd_addr 8'h03, cmd_wdata 8'hA5, SETUP_CYCLES 1 -> port_id 8'h03 for 2 cycles, write_strobe high for exactly 1 cycle with out_port 8'hA5.
REQ-021 Read cmd_addr 8'h10, in_port 8'h5C -> read_strobe 1 cycle; rsp_valid 3 cycles after acceptance with rsp_data 8'h5C.
REQ-022 Read with rsp_ready held low for 10 cycles -> rsp_valid and rsp_data stable, cmd_ready 0 throughout, no further strobes.
REQ-023 reset driven low in the STROBE cycle -> strobes drop at once, no rsp_valid, cmd_ready 1 after release.
REQ-024 SETUP_CYCLES 15, back-to-back writes with cmd_valid held high -> strobes exactly 17 cycles apart.
REQ-025 With PB_BUS_MASTER_IRQ_EN, interrupt pulse then irq_clear -> irq_pending rises 3 cycles after the edge and falls 1 cycle after the clear; without the macro it stays 0.

Source files
------------

// File: rtl/pb_bus_pkg.sv
// Shared definitions for the Picoblaze-style port bus master: FSM state encoding and data width.
package pb_bus_pkg;

    localparam int PB_DATA_W      = 8;
    localparam int PB_SETUP_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        RESP   = 2'd3
    } pb_state_e;

endpackage

// File: rtl/pb_irq_sync.sv
// Interrupt synchronizer (2 flops) plus rising-edge latch for pb_bus_master.
// Only instantiated when PB_BUS_MASTER_IRQ_EN is defined.
module pb_irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic interrupt,
    input  logic irq_clear,
    output logic irq_pending
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q,  hist_d;
    logic pending_q, pending_d;
    logic rise;

    always_comb begin
        sync1_d   = interrupt;
        sync2_d   = sync1_q;
        hist_d    = sync2_q;
        rise      = sync2_q & ~hist_q;
        pending_d = pending_q;
        // A fresh edge wins over a clear arriving in the same cycle.
        if (rise) begin
            pending_d = 1'b1;
        end else if (irq_clear) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            hist_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            hist_q    <= hist_d;
            pending_q <= pending_d;
        end
    end

    assign irq_pending = pending_q;

endmodule

// File: rtl/pb_bus_master.sv
// Command/response front end driving a Picoblaze-style port bus (port_id/out_port/strobes).
// Optional interrupt latch enabled by defining PB_BUS_MASTER_IRQ_EN.
module pb_bus_master
    import pb_bus_pkg::*;
#(
    parameter int SETUP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [PB_DATA_W-1:0] cmd_addr,
    input  logic [PB_DATA_W-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [PB_DATA_W-1:0] rsp_data,
    output logic [PB_DATA_W-1:0] port_id,
    output logic [PB_DATA_W-1:0] out_port,
    input  logic [PB_DATA_W-1:0] in_port,
    output logic                 write_strobe,
    output logic                 read_strobe,
    input  logic                 interrupt,
    output logic                 irq_pending,
    input  logic                 irq_clear
);

    generate
        if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
            $error("pb_bus_master: SETUP_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [PB_SETUP_CNT_W-1:0] SETUP_LAST = PB_SETUP_CNT_W'(SETUP_CYCLES);

    pb_state_e                 state_q, state_d;
    logic [PB_SETUP_CNT_W-1:0] cnt_q, cnt_d;
    logic                      dir_q, dir_d;
    logic [PB_DATA_W-1:0]      port_id_q, port_id_d;
    logic [PB_DATA_W-1:0]      out_port_q, out_port_d;
    logic [PB_DATA_W-1:0]      rsp_data_q, rsp_data_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        port_id_d    = port_id_q;
        out_port_d   = out_port_q;
        rsp_data_d   = rsp_data_q;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        write_strobe = 1'b0;
        read_strobe  = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d    = SETUP;
                    cnt_d      = PB_SETUP_CNT_W'(1);
                    dir_d      = cmd_write;
                    port_id_d  = cmd_addr;
                    out_port_d = cmd_wdata;
                end
            end
            SETUP: begin
                // Counter starts at 1 and stops at SETUP_LAST, so it never wraps.
                if (cnt_q == SETUP_LAST) begin
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q + PB_SETUP_CNT_W'(1);
                end
            end
            STROBE: begin
                write_strobe = dir_q;
                read_strobe  = ~dir_q;
                if (dir_q) begin
                    state_d = IDLE;
                end else begin
                    rsp_data_d = in_port;
                    state_d    = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            port_id_q  <= '0;
            out_port_q <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            port_id_q  <= port_id_d;
            out_port_q <= out_port_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign port_id  = port_id_q;
    assign out_port = out_port_q;
    assign rsp_data = rsp_data_q;

`ifdef PB_BUS_MASTER_IRQ_EN
    pb_irq_sync u_irq_sync (
        .clk         (clk),
        .reset       (reset),
        .interrupt   (interrupt),
        .irq_clear   (irq_clear),
        .irq_pending (irq_pending)
    );
`else
    logic unused_irq;
    assign unused_irq  = interrupt ^ irq_clear;
    assign irq_pending = 1'b0;
`endif

endmodule

// File: tb/tb_pb_bus_master.sv
// Directed bench for pb_bus_master: one instance with SETUP_CYCLES=1, one with SETUP_CYCLES=15.
module tb_pb_bus_master;

`ifdef PB_BUS_MASTER_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data, port_id, out_port, in_port;
    logic       write_strobe, read_strobe;
    logic       interrupt, irq_pending, irq_clear;

    logic       c15_valid, c15_ready, c15_write;
    logic [7:0] c15_addr, c15_wdata;
    logic       r15_valid;
    logic [7:0] r15_data, p15_id, p15_out;
    logic       w15_stb, r15_stb, irq15;

    int errors = 0;
    int checks = 0;
    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic [15:0] wr15_q[$];

    always #5 clk = ~clk;

    pb_bus_master #(.SETUP_CYCLES(1)) dut (
        .clk(clk), .reset(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .port_id(port_id), .out_port(out_port), .in_port(in_port),
        .write_strobe(write_strobe), .read_strobe(read_strobe),
        .interrupt(interrupt), .irq_pending(irq_pending), .irq_clear(irq_clear)
    );

    pb_bus_master #(.SETUP_CYCLES(15)) dut15 (
        .clk(clk), .reset(rst_n),
        .cmd_valid(c15_valid), .cmd_ready(c15_ready), .cmd_write(c15_write),
        .cmd_addr(c15_addr), .cmd_wdata(c15_wdata),
        .rsp_valid(r15_valid), .rsp_ready(1'b1), .rsp_data(r15_data),
        .port_id(p15_id), .out_port(p15_out), .in_port(8'h00),
        .write_strobe(w15_stb), .read_strobe(r15_stb),
        .interrupt(1'b0), .irq_pending(irq15), .irq_clear(1'b0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command to the SETUP_CYCLES=1 instance and follow it to completion.
    task automatic run_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                           input int hold);
        int strobe_at, done_at, wstb, rstb;
        logic [15:0] exp_w;
        logic [7:0]  exp_r;
        strobe_at = -1; done_at = -1; wstb = 0; rstb = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
        if (wr) wr_q.push_back({addr, data});
        else begin rd_q.push_back(data); in_port = data; end
        chk("ready_before_accept", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0; cmd_addr = ~addr; cmd_wdata = ~data;
        for (int n = 1; n <= 40 && done_at < 0; n++) begin
            if (strobe_at > 0 && n > strobe_at) in_port = ~data;
            if (write_strobe || read_strobe) begin
                if (strobe_at < 0) strobe_at = n;
                wstb += int'(write_strobe);
                rstb += int'(read_strobe);
                chk("strobe_port_id", port_id, addr);
                if (write_strobe) begin
                    if (wr_q.size() > 0) exp_w = wr_q.pop_front(); else exp_w = 16'hxxxx;
                    chk("wr_port_id", port_id, exp_w[15:8]);
                    chk("wr_out_port", out_port, exp_w[7:0]);
                end
            end else if (strobe_at < 0) begin
                chk("setup_port_id", port_id, addr);
                chk("setup_out_port", out_port, data);
                chk("setup_ready_low", cmd_ready, 1'b0);
            end
            if ((wr && cmd_ready) || (!wr && rsp_valid)) done_at = n;
            else step();
        end
        chk("strobe_latency", strobe_at, 2);
        chk("done_latency", done_at, 3);
        chk("wstb_count", wstb, wr ? 1 : 0);
        chk("rstb_count", rstb, wr ? 0 : 1);
        if (wr) begin
            chk("idle_port_id_kept", port_id, addr);
            chk("idle_out_port_kept", out_port, data);
        end else begin
            if (rd_q.size() > 0) exp_r = rd_q.pop_front(); else exp_r = 8'hxx;
            chk("rsp_data", rsp_data, exp_r);
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'hEE; cmd_wdata = 8'h11;
            for (int i = 0; i < hold; i++) begin
                chk("hold_rsp_valid", rsp_valid, 1'b1);
                chk("hold_rsp_data", rsp_data, exp_r);
                chk("hold_cmd_ready", cmd_ready, 1'b0);
                chk("hold_no_strobe", {write_strobe, read_strobe}, 2'b00);
                step();
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            chk("rsp_done_ready", cmd_ready, 1'b1);
            chk("rsp_done_valid", rsp_valid, 1'b0);
            chk("rd_idle_port_id_kept", port_id, addr);
        end
    endtask

    initial begin
        int t_prev, stb15, k;
        int diffs[$];
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
        rsp_ready = 1'b0; in_port = 8'h00; interrupt = 1'b0; irq_clear = 1'b0;
        c15_valid = 1'b0; c15_write = 1'b1; c15_addr = 8'h00; c15_wdata = 8'h00;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_port_id", port_id, 8'h00);
        chk("rst_out_port", out_port, 8'h00);
        chk("rst_strobes", {write_strobe, read_strobe}, 2'b00);
        chk("rst_irq_pending", irq_pending, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", cmd_ready, 1'b1);

        run_cmd(1'b1, 8'h03, 8'hA5, 0);
        run_cmd(1'b0, 8'h10, 8'h5C, 0);
        run_cmd(1'b0, 8'h00, 8'hC3, 10);
        run_cmd(1'b1, 8'hFF, 8'h00, 0);
        run_cmd(1'b0, 8'h7E, 8'hFF, 2);

        // Reset pulled low during the STROBE cycle of a read.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h22; cmd_wdata = 8'h33; in_port = 8'h77;
        step();
        cmd_valid = 1'b0;
        step();
        chk("abort_in_strobe", read_strobe, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_strobes", {write_strobe, read_strobe}, 2'b00);
        chk("abort_ready", cmd_ready, 1'b1);
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        chk("abort_port_id", port_id, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("after_abort_ready", cmd_ready, 1'b1);
            chk("after_abort_no_rsp", rsp_valid, 1'b0);
            chk("after_abort_no_strobe", {write_strobe, read_strobe}, 2'b00);
        end

        // Back-to-back writes on the SETUP_CYCLES=15 instance with cmd_valid held high.
        k = 0; stb15 = 0; t_prev = -1;
        c15_valid = 1'b1;
        for (int n = 0; n < 90 && stb15 < 3; n++) begin
            if (c15_ready) begin
                c15_addr = 8'h40 + 8'(k);
                c15_wdata = 8'h90 + 8'(k);
                wr15_q.push_back({c15_addr, c15_wdata});
                k++;
            end
            if (w15_stb) begin
                logic [15:0] e;
                if (wr15_q.size() > 0) e = wr15_q.pop_front(); else e = 16'hxxxx;
                chk("b2b_port_id", p15_id, e[15:8]);
                chk("b2b_out_port", p15_out, e[7:0]);
                if (t_prev >= 0) diffs.push_back(n - t_prev);
                t_prev = n;
                stb15++;
                if (stb15 == 3) c15_valid = 1'b0;
            end
            if (stb15 < 3) step();
        end
        chk("b2b_strobe_count", stb15, 3);
        chk("b2b_diff_count", diffs.size(), 2);
        foreach (diffs[i]) chk("b2b_strobe_spacing", diffs[i], 17);
        step();
        chk("b2b_idle_after", c15_ready, 1'b1);
        chk("b2b_no_extra_strobe", w15_stb, 1'b0);

        // Interrupt edge latch.
        interrupt = 1'b1;
        step(); chk("irq_e1", irq_pending, 1'b0);
        step(); chk("irq_e2", irq_pending, 1'b0);
        step(); chk("irq_e3", irq_pending, IRQ_ON);
        interrupt = 1'b0;
        step(); chk("irq_latched", irq_pending, IRQ_ON);
        irq_clear = 1'b1;
        step(); chk("irq_cleared", irq_pending, 1'b0);
        irq_clear = 1'b0;
        step(); chk("irq_stays_clear", irq_pending, 1'b0);
        interrupt = 1'b1;
        step();
        step();
        irq_clear = 1'b1;
        step(); chk("irq_edge_beats_clear", irq_pending, IRQ_ON);
        irq_clear = 1'b0; interrupt = 1'b0;
        step(); chk("irq_still_set", irq_pending, IRQ_ON);
        irq_clear = 1'b1;
        step(); chk("irq_final_clear", irq_pending, 1'b0);
        irq_clear = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
